// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matmul_pkg
// Description : Shared FSM state encoding and width helpers for the
//               matrix_mult_n block (matrix_mult_n.sv, matrix_mult_n_mac.sv).
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

   // Controller states. The encoding width is stated explicitly.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_MAC  = 3'd2,
      ST_XOR  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Ceiling log2, never below 1 so that counters always have at least one bit.
   function automatic int unsigned f_clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned w = 0; w < 32; w++) begin
         if ((64'd1 << w) < 64'(value)) r = w + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

   // Address width of an N*N element RAM.
   function automatic int unsigned f_addr_w(input int unsigned n);
      return f_clog2(n * n);
   endfunction

   // Width of a row/column/inner-product index counter.
   function automatic int unsigned f_idx_w(input int unsigned n);
      return f_clog2(n);
   endfunction

endpackage : matmul_pkg
`default_nettype wire

// File: rtl/matrix_mult_n_mac.sv
`default_nettype none
// ============================================================================
// Module      : mac_unit
// Description : Unsigned DW x DW multiply-accumulate into a CW-bit register.
//               clr restarts the accumulation with the current product;
//               the sum wraps modulo 2^CW.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_unit #(
   parameter int DW = 8,
   parameter int CW = 20
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [CW-1:0] acc
);

   // The accumulator must be strictly wider than a single product.
   if (CW <= 2 * DW) begin : g_bad_cw
      $error("mac_unit: CW must exceed 2*DW");
   end

   logic [2*DW-1:0] w_prod;
   logic [CW-1:0]   w_prod_ext;
   logic [CW-1:0]   acc_q;

   assign w_prod     = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
   assign w_prod_ext = {{(CW - 2 * DW){1'b0}}, w_prod};
   assign acc        = acc_q;

   // Accumulate one product per enabled cycle, restarting on clr.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
      end else if (en) begin
         acc_q <= clr ? w_prod_ext : (acc_q + w_prod_ext);
      end
   end

endmodule : mac_unit
`default_nettype wire

// File: rtl/matrix_mult_n.sv
`default_nettype none
// ============================================================================
// Module      : matrix_mult_n
// Description : Sequential N x N unsigned matrix multiplier. Loads A and B
//               into internal RAMs, computes C = A*B with one MAC per cycle,
//               then XOR-folds all C elements into final_xor.
//               Optional macro MATMUL_C_OUT_EN adds the matrix_c output.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_mult_n
   import matmul_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int CW = 20
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [N*N*DW-1:0] A,
   input  logic [N*N*DW-1:0] B,
   output logic              busy,
   output logic              done,
   output logic [CW-1:0]     final_xor,
   output logic [15:0]       mult_count
`ifdef MATMUL_C_OUT_EN
   ,
   output logic [N*N*CW-1:0] matrix_c
`endif
);

   localparam int c_EL = N * N;
   localparam int c_AW = f_addr_w(N);
   localparam int c_IW = f_idx_w(N);
   localparam int c_MW = f_clog2(N * N * N + 2);
   localparam int c_XW = f_clog2(c_EL + 1);

   typedef logic [c_AW-1:0] addr_t;

   localparam logic [c_IW-1:0] c_IDX_MAX   = c_IW'(N - 1);
   localparam addr_t           c_EL_LAST   = addr_t'(c_EL - 1);
   localparam logic [c_MW-1:0] c_MAC_ISSUE = c_MW'(N * N * N);
   localparam logic [c_MW-1:0] c_MAC_LAST  = c_MW'(N * N * N + 1);
   localparam logic [c_XW-1:0] c_X_LAST    = c_XW'(c_EL);

   // Elaboration-time parameter sanity.
   if (N < 2 || N > 16) begin : g_bad_n
      $error("matrix_mult_n: N must be in 2..16");
   end
   if (CW < 2 * DW + f_clog2(N)) begin : g_bad_cw
      $error("matrix_mult_n: CW too narrow for N accumulated products");
   end

   state_e          state_q, state_d;
   addr_t           load_cnt_q;
   logic [c_IW-1:0] i_q, j_q, k_q;
   logic [c_MW-1:0] mac_cnt_q;
   logic [c_XW-1:0] x_cnt_q;

   logic            s1_vld_q, s1_first_q, s1_last_q;
   addr_t           s1_caddr_q;
   logic            s2_wr_q;
   addr_t           s2_caddr_q;
   logic            x_vld_q;

   logic [DW-1:0]   a_ram [c_EL];
   logic [DW-1:0]   b_ram [c_EL];
   logic [CW-1:0]   c_ram [c_EL];
   logic [DW-1:0]   a_rd_q, b_rd_q;
   logic [CW-1:0]   c_rd_q;

   logic [CW-1:0]   final_xor_q;
   logic [15:0]     mult_count_q;
   logic [CW-1:0]   w_acc;

   logic            w_accept, w_issue, w_xrd;
   logic            w_load_last, w_mac_last, w_x_last;
   addr_t           w_a_addr, w_b_addr, w_c_addr;

   assign w_accept    = (state_q == ST_IDLE) && start;
   assign w_issue     = (state_q == ST_MAC) && (mac_cnt_q < c_MAC_ISSUE);
   assign w_xrd       = (state_q == ST_XOR) && (x_cnt_q < c_X_LAST);
   assign w_load_last = (load_cnt_q == c_EL_LAST);
   assign w_mac_last  = (mac_cnt_q == c_MAC_LAST);
   assign w_x_last    = (x_cnt_q == c_X_LAST);

   // Row-major addresses: A(i,k), B(k,j) and the destination C(i,j).
   assign w_a_addr = addr_t'(i_q) * addr_t'(N) + addr_t'(k_q);
   assign w_b_addr = addr_t'(k_q) * addr_t'(N) + addr_t'(j_q);
   assign w_c_addr = addr_t'(i_q) * addr_t'(N) + addr_t'(j_q);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; the drain cycles are folded into the MAC count.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)       state_d = ST_LOAD;
         ST_LOAD: if (w_load_last) state_d = ST_MAC;
         ST_MAC:  if (w_mac_last)  state_d = ST_XOR;
         ST_XOR:  if (w_x_last)    state_d = ST_DONE;
         ST_DONE:                  state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // Status outputs decoded from the state.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         ST_LOAD, ST_MAC, ST_XOR: busy = 1'b1;
         ST_DONE:                 done = 1'b1;
         default: ;
      endcase
   end

   // Phase counters: load index, i/j/k loop nest with drain count, XOR index.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         load_cnt_q <= '0;
         i_q        <= '0;
         j_q        <= '0;
         k_q        <= '0;
         mac_cnt_q  <= '0;
         x_cnt_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               load_cnt_q <= '0;
               i_q        <= '0;
               j_q        <= '0;
               k_q        <= '0;
               mac_cnt_q  <= '0;
               x_cnt_q    <= '0;
            end
            ST_LOAD: load_cnt_q <= w_load_last ? '0 : (load_cnt_q + 1'b1);
            ST_MAC: begin
               mac_cnt_q <= w_mac_last ? '0 : (mac_cnt_q + 1'b1);
               if (w_issue) begin
                  if (k_q == c_IDX_MAX) begin
                     k_q <= '0;
                     if (j_q == c_IDX_MAX) begin
                        j_q <= '0;
                        i_q <= (i_q == c_IDX_MAX) ? '0 : (i_q + 1'b1);
                     end else begin
                        j_q <= j_q + 1'b1;
                     end
                  end else begin
                     k_q <= k_q + 1'b1;
                  end
               end
            end
            ST_XOR: x_cnt_q <= w_x_last ? '0 : (x_cnt_q + 1'b1);
            default: ;
         endcase
      end
   end

   // Pipeline tags that follow each read pair through RAM latency and the MAC.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_vld_q   <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_caddr_q <= '0;
         s2_wr_q    <= 1'b0;
         s2_caddr_q <= '0;
         x_vld_q    <= 1'b0;
      end else begin
         s1_vld_q   <= w_issue;
         s1_first_q <= (k_q == '0);
         s1_last_q  <= (k_q == c_IDX_MAX);
         s1_caddr_q <= w_c_addr;
         s2_wr_q    <= s1_vld_q && s1_last_q;
         s2_caddr_q <= s1_caddr_q;
         x_vld_q    <= w_xrd;
      end
   end

   // Inferred RAMs with registered reads; contents are never reset.
   always_ff @(posedge clock) begin
      if (state_q == ST_LOAD) begin
         a_ram[load_cnt_q] <= A[load_cnt_q * DW +: DW];
         b_ram[load_cnt_q] <= B[load_cnt_q * DW +: DW];
      end
      if (s2_wr_q) c_ram[s2_caddr_q] <= w_acc;
      a_rd_q <= a_ram[w_a_addr];
      b_rd_q <= b_ram[w_b_addr];
      c_rd_q <= c_ram[x_cnt_q[c_AW-1:0]];
   end

   mac_unit #(
      .DW (DW),
      .CW (CW)
   ) u_mac (
      .clock (clock),
      .reset (reset),
      .clr   (s1_first_q),
      .en    (s1_vld_q),
      .a     (a_rd_q),
      .b     (b_rd_q),
      .acc   (w_acc)
   );

   // Run results: cleared on accepted start, held in IDLE afterwards.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         final_xor_q  <= '0;
         mult_count_q <= '0;
      end else if (w_accept) begin
         final_xor_q  <= '0;
         mult_count_q <= '0;
      end else begin
         if (s1_vld_q) mult_count_q <= mult_count_q + 16'd1;
         if (x_vld_q)  final_xor_q  <= final_xor_q ^ c_rd_q;
      end
   end

   assign final_xor  = final_xor_q;
   assign mult_count = mult_count_q;

`ifdef MATMUL_C_OUT_EN
   logic [N*N*CW-1:0] matrix_c_q;

   // Mirror of each C element as it is written to the C RAM.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         matrix_c_q <= '0;
      end else if (w_accept) begin
         matrix_c_q <= '0;
      end else if (s2_wr_q) begin
         matrix_c_q[s2_caddr_q * CW +: CW] <= w_acc;
      end
   end

   assign matrix_c = matrix_c_q;
`endif

endmodule : matrix_mult_n
`default_nettype wire

// File: tb/tb_matrix_mult_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_mult_n
// Description : Self-checking bench for matrix_mult_n (N=4 and N=2 instances)
//               against a plain-arithmetic matrix product model.
//               Honours MATMUL_C_OUT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_mult_n;

   localparam int DW = 8;
   localparam int CW = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              start4, start2;
   logic [16*DW-1:0]  A4, B4;
   logic [4*DW-1:0]   A2, B2;
   logic              busy4, done4, busy2, done2;
   logic [CW-1:0]     fx4, fx2;
   logic [15:0]       mc4, mc2;
`ifdef MATMUL_C_OUT_EN
   logic [16*CW-1:0]  mat4;
   logic [4*CW-1:0]   mat2;
`endif

   matrix_mult_n #(.N(4), .DW(DW), .CW(CW)) u_dut4 (
      .clock(clk), .reset(rst), .start(start4), .A(A4), .B(B4),
      .busy(busy4), .done(done4), .final_xor(fx4), .mult_count(mc4)
`ifdef MATMUL_C_OUT_EN
      , .matrix_c(mat4)
`endif
   );

   matrix_mult_n #(.N(2), .DW(DW), .CW(CW)) u_dut2 (
      .clock(clk), .reset(rst), .start(start2), .A(A2), .B(B2),
      .busy(busy2), .done(done2), .final_xor(fx2), .mult_count(mc2)
`ifdef MATMUL_C_OUT_EN
      , .matrix_c(mat2)
`endif
   );

   int checks   = 0;
   int failures = 0;

   int unsigned   ma [16];
   int unsigned   mb [16];
   logic [CW-1:0] cref [16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: C = A*B mod 2^CW, then XOR of all elements.
   task automatic model(input int n, output logic [CW-1:0] xr);
      longint sum;
      xr = '0;
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < n; j++) begin
            sum = 0;
            for (int k = 0; k < n; k++) sum += longint'(ma[i*n+k]) * longint'(mb[k*n+j]);
            cref[i*n+j] = sum[CW-1:0];
            xr ^= cref[i*n+j];
         end
      end
   endtask

   task automatic load_inputs(input int n);
      for (int e = 0; e < n*n; e++) begin
         if (n == 4) begin A4[e*DW +: DW] = ma[e][DW-1:0]; B4[e*DW +: DW] = mb[e][DW-1:0]; end
         else        begin A2[e*DW +: DW] = ma[e][DW-1:0]; B2[e*DW +: DW] = mb[e][DW-1:0]; end
      end
   endtask

   // Waits (bounded) for done after an accepting edge; optional one-cycle start pulse.
   task automatic wait_done(input int n, input int glitch_at, output int cyc, output bit busy_ok);
      cyc = 0;
      busy_ok = 1'b1;
      while (cyc < 1000) begin
         @(posedge clk);
         cyc++;
         #1;
         if (glitch_at >= 0) begin
            if (n == 4) start4 = (cyc == glitch_at); else start2 = (cyc == glitch_at);
         end
         if ((n == 4) ? done4 : done2) break;
         if (!((n == 4) ? busy4 : busy2)) busy_ok = 1'b0;
      end
      if (glitch_at >= 0) begin start4 = 1'b0; start2 = 1'b0; end
   endtask

   task automatic run(input string tag, input int n, input int glitch_at);
      logic [CW-1:0] xr;
      int            cyc;
      bit            busy_ok;
      model(n, xr);
      load_inputs(n);
      @(negedge clk);
      if (n == 4) start4 = 1'b1; else start2 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      start2 = 1'b0;
      chk({tag, ".busy_on_accept"}, (n == 4) ? busy4 : busy2, 1);
      wait_done(n, glitch_at, cyc, busy_ok);
      chk({tag, ".latency"}, cyc, 2*n*n + n*n*n + 3);
      chk({tag, ".busy_held"}, busy_ok, 1);
      chk({tag, ".final_xor"}, (n == 4) ? fx4 : fx2, xr);
      chk({tag, ".mult_count"}, (n == 4) ? mc4 : mc2, n*n*n);
`ifdef MATMUL_C_OUT_EN
      for (int e = 0; e < n*n; e++)
         chk({tag, ".matrix_c"}, (n == 4) ? mat4[e*CW +: CW] : mat2[e*CW +: CW], cref[e]);
`endif
      @(posedge clk);
      #1;
      chk({tag, ".done_one_cycle"}, (n == 4) ? done4 : done2, 0);
      chk({tag, ".busy_dropped"}, (n == 4) ? busy4 : busy2, 0);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, ".xor_held"}, (n == 4) ? fx4 : fx2, xr);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            cyc;
      int            pulses;
      bit            busy_ok;
      logic [CW-1:0] xr;

      rst = 1'b1; start4 = 1'b0; start2 = 1'b0;
      A4 = '0; B4 = '0; A2 = '0; B2 = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy4", busy4, 0);
      chk("rst.done4", done4, 0);
      chk("rst.xor4", fx4, 0);
      chk("rst.cnt4", mc4, 0);
      chk("rst.busy2", busy2, 0);
      chk("rst.cnt2", mc2, 0);
      @(negedge clk);
      rst = 1'b0;

      // Identity x (1..16).
      for (int e = 0; e < 16; e++) begin ma[e] = (e / 4 == e % 4) ? 1 : 0; mb[e] = e + 1; end
      run("ident", 4, -1);
      chk("ident.xor_is_16", fx4, 16);

      // All 0xFF: every element 4*255*255, no overflow.
      for (int e = 0; e < 16; e++) begin ma[e] = 255; mb[e] = 255; end
      run("allff", 4, -1);
      chk("allff.xor_is_0", fx4, 0);
`ifdef MATMUL_C_OUT_EN
      chk("allff.c0", mat4[0 +: CW], 260100);
`endif

      // 2x2 worked example.
      ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4;
      mb[0] = 5; mb[1] = 6; mb[2] = 7; mb[3] = 8;
      run("ex2x2", 2, -1);
      chk("ex2x2.xor_is_28", fx2, 28);
`ifdef MATMUL_C_OUT_EN
      chk("ex2x2.matrix_c", mat2, {20'd50, 20'd43, 20'd22, 20'd19});
`endif

      // Random matrices.
      for (int t = 0; t < 3; t++) begin
         for (int e = 0; e < 16; e++) begin ma[e] = $urandom_range(0, 255); mb[e] = $urandom_range(0, 255); end
         run("rand4", 4, -1);
      end
      for (int t = 0; t < 2; t++) begin
         for (int e = 0; e < 4; e++) begin ma[e] = $urandom_range(0, 255); mb[e] = $urandom_range(0, 255); end
         run("rand2", 2, -1);
      end

      // Start pulse during MAC is ignored; only one done follows.
      for (int e = 0; e < 16; e++) begin ma[e] = $urandom_range(0, 255); mb[e] = $urandom_range(0, 255); end
      run("glitch", 4, 30);
      pulses = 0;
      for (int c = 0; c < 120; c++) begin @(posedge clk); #1; if (done4) pulses++; end
      chk("glitch.no_extra_done", pulses, 0);

      // Start held high through the run restarts from the following IDLE cycle.
      model(4, xr);
      load_inputs(4);
      @(negedge clk);
      start4 = 1'b1;
      @(posedge clk);
      #1;
      wait_done(4, -1, cyc, busy_ok);
      chk("hold.latency1", cyc, 99);
      @(posedge clk);
      #1;
      chk("hold.idle_gap", busy4, 0);
      @(posedge clk);
      #1;
      chk("hold.restarted", busy4, 1);
      start4 = 1'b0;
      wait_done(4, -1, cyc, busy_ok);
      chk("hold.latency2", cyc, 99);
      chk("hold.final_xor", fx4, xr);

      // Reset in the middle of MAC aborts the run.
      for (int e = 0; e < 16; e++) begin ma[e] = $urandom_range(1, 255); mb[e] = $urandom_range(1, 255); end
      load_inputs(4);
      @(negedge clk);
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort.busy", busy4, 0);
      chk("abort.done", done4, 0);
      chk("abort.xor", fx4, 0);
      chk("abort.cnt", mc4, 0);
      pulses = 0;
      for (int c = 0; c < 5; c++) begin @(posedge clk); #1; if (done4 || busy4) pulses++; end
      chk("abort.quiet_in_reset", pulses, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int e = 0; e < 16; e++) begin ma[e] = (e / 4 == e % 4) ? 1 : 0; mb[e] = ma[e]; end
      run("restart", 4, -1);
      chk("restart.xor_is_0", fx4, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_matrix_mult_n
`default_nettype wire

// File: doc/matrix_mult_n.md
MATRIX_MULT_N -- requirements
Module: matrix_mult_n

Interface
REQ-001 SHALL have parameter N, default 4, matrix dimension (2..16).
REQ-002 SHALL have parameter DW, default 8, unsigned element width.
REQ-003 SHALL have parameter CW, default 20, result/accumulator width; elaboration SHALL fail if CW < 2*DW + clog2(N).
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request to begin one multiply, sampled only in IDLE.
REQ-007 SHALL have ports A, B  input  N*N*DW  row-major flattened matrices; element (i,j) at bits [(i*N+j)*DW +: DW].
REQ-008 SHALL have port busy  output  1  high from start acceptance until done.
REQ-009 SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port final_xor  output  CW  XOR of all N*N elements of C = A*B.
REQ-011 SHALL have port mult_count  output  16  number of products accumulated in the current/last run.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, MAC, XOR, DONE.
REQ-013 IDLE with start=1 SHALL move to LOAD, set busy, clear final_xor and mult_count.
REQ-014 LOAD SHALL write element k of A and B into internal RAMs at address k, k=0..N*N-1, one per cycle (N*N cycles); A/B changes after LOAD have no effect.
REQ-015 MAC SHALL issue one A/B read pair per cycle in order i, j, k (N^3 cycles); RAM read latency 1 cycle; accumulator cleared on k=0 product, C(i,j) written to C RAM address i*N+j after k=N-1 product; 2 drain cycles follow.
REQ-016 Products SHALL be unsigned DW x DW; accumulation modulo 2^CW.
REQ-017 mult_count SHALL increment once per accumulated product, reaching N^3 at done.
REQ-018 XOR SHALL read C addresses 0..N*N-1, one per cycle, folding each into final_xor (N*N + 1 cycles incl. read latency).
REQ-019 DONE SHALL assert done for exactly one cycle, drop busy, return to IDLE.
REQ-020 done SHALL assert exactly 2*N*N + N^3 + 3 cycles after the start-accepting edge (99 for N=4).
REQ-021 start while busy SHALL be ignored; start held high through DONE SHALL begin a new run from the following IDLE cycle.
REQ-022 final_xor and mult_count SHALL hold their last values in IDLE until the next accepted start.

Reset
REQ-023 reset SHALL asynchronously force IDLE, busy=0, done=0, final_xor=0, mult_count=0, all address/loop counters 0.
REQ-024 reset asserted mid-run SHALL abort the run; no done pulse is produced for the aborted run.
REQ-025 RAM contents are not reset; every run SHALL overwrite all locations before reading them.

Configuration
REQ-026 Macro MATMUL_C_OUT_EN defined: SHALL add output matrix_c (N*N*CW, row-major), each element registered as written in MAC and held until next start, reset to 0.
REQ-027 Macro MATMUL_C_OUT_EN undefined: matrix_c port and its registers SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package matmul_pkg SHALL hold the FSM state enum and clog2-derived address-width constants/functions.
REQ-029 Multiply-accumulate SHALL be sub-module mac_unit (ports clock, reset, clr, en, a, b, acc); RAMs are inferred inside matrix_mult_n.

Verification
REQ-030 N=4, A=identity, B elements 1..16 -> final_xor=16, mult_count=64, done exactly 99 cycles after start.
REQ-031 N=4, all A,B = 0xFF -> every C=260100, final_xor=0, no overflow.
REQ-032 N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> C=[[19,22],[43,50]], final_xor=28, done at cycle 19.
REQ-033 Pulse start during MAC -> ignored; single done; result unchanged.
REQ-034 Assert reset mid-MAC, then restart with identity x identity (N=4) -> busy/done/final_xor=0 during reset; new run gives final_xor=0 (16 C elements: four 1s, twelve 0s), mult_count=64.
REQ-035 With MATMUL_C_OUT_EN, repeat REQ-032 -> matrix_c equals {50,43,22,19} packed row-major.
